// File: rtl/capture_pkg.sv
// Shared definitions for the capture sequencer: state encoding, HPS command
// bit positions and the default frame-edge watchdog limit.
package capture_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_STREAM = 3'd2,
    S_SNAP   = 3'd3,
    S_HOLD   = 3'd4
  } state_t;

  localparam int CMD_RUN   = 0;
  localparam int CMD_SNAP  = 1;
  localparam int CMD_ABORT = 2;

  localparam int TIMEOUT_CYCLES_DEFAULT = 50_000_000;

endpackage

// File: rtl/fval_edge_sync.sv
// Brings the camera frame-valid into the system clock domain and flags the
// end of each frame (falling edge of the synchronized level) for one cycle.
module fval_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic fval,
  output logic fall
);

  logic sync1;
  logic sync2;
  logic sync2_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour, giving a true shift chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1   <= fval;
      sync2   <= sync1;
      sync2_q <= sync2;
    end
  end

  // Left combinational so the sequencer reacts on the third edge after fval drops.
  assign fall = sync2_q & ~sync2;

endmodule

// File: rtl/capture_sequencer.sv
// Frame-aligned capture sequencer between the HPS command word and the CCD
// capture block. Optional frame-edge watchdog: define CAPTURE_SEQ_WATCHDOG_EN.
module capture_sequencer
  import capture_pkg::*;
#(
  parameter int SNAP_W         = 8,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic [2:0]        iCMD,
  input  logic              iFVAL,
  input  logic [SNAP_W-1:0] iSNAP_FRAMES,
  output logic              oSTART,
  output logic              oEND,
  output logic              oREADY,
  output logic [SNAP_W-1:0] oFRAME_CNT,
  output logic [2:0]        oSTATE,
  output logic              oTIMEOUT
);

  state_t            state, state_next;
  logic [SNAP_W-1:0] frame_cnt, frame_cnt_next;
  logic [SNAP_W-1:0] snap_n, snap_n_next;
  logic [SNAP_W-1:0] cnt_inc;
  logic              run_q, snap_q;
  logic              run_rise, run_fall, snap_rise, abort;
  logic              frame_end;
  logic              wd_hit;

  fval_edge_sync u_fval_sync (
    .clk   (iCLK),
    .rst_n (iRST_N),
    .fval  (iFVAL),
    .fall  (frame_end)
  );

  assign run_rise  =  iCMD[CMD_RUN]  & ~run_q;
  assign run_fall  = ~iCMD[CMD_RUN]  &  run_q;
  assign snap_rise =  iCMD[CMD_SNAP] & ~snap_q;
  assign abort     =  iCMD[CMD_ABORT];

  assign cnt_inc = (frame_cnt == '1) ? frame_cnt : frame_cnt + SNAP_W'(1);

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state     <= S_IDLE;
      frame_cnt <= '0;
      snap_n    <= '0;
      run_q     <= 1'b0;
      snap_q    <= 1'b0;
    end else begin
      state     <= state_next;
      frame_cnt <= frame_cnt_next;
      snap_n    <= snap_n_next;
      run_q     <= iCMD[CMD_RUN];
      snap_q    <= iCMD[CMD_SNAP];
    end
  end

  // NOTE: every output of this block is given a default before the case
  // statement, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next     = state;
    frame_cnt_next = frame_cnt;
    snap_n_next    = snap_n;
    if (abort || wd_hit) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (run_rise) state_next = S_ARM;
        S_ARM:    if (frame_end) state_next = S_STREAM;
        S_STREAM: begin
          if (run_fall) begin
            state_next = S_IDLE;
          end else if (snap_rise) begin
            snap_n_next    = (iSNAP_FRAMES == '0) ? SNAP_W'(1) : iSNAP_FRAMES;
            frame_cnt_next = '0;
            state_next     = S_SNAP;
          end
        end
        S_SNAP: begin
          if (frame_end) begin
            frame_cnt_next = cnt_inc;
            if (cnt_inc >= snap_n) state_next = S_HOLD;
          end
        end
        S_HOLD:   if (!iCMD[CMD_RUN]) state_next = S_IDLE;
        default:  state_next = S_IDLE;
      endcase
    end
  end

`ifdef CAPTURE_SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            timeout;
  logic            wd_active;

  assign wd_active = (state == S_ARM) || (state == S_SNAP);
  // A boundary arriving on the limit cycle counts as progress, not a stall.
  assign wd_hit    = wd_active && !frame_end && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      wd_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      if (!wd_active || frame_end) wd_cnt <= '0;
      else                         wd_cnt <= wd_cnt + WD_W'(1);
      if (wd_hit && !abort) timeout <= 1'b1;
      else if (run_rise)    timeout <= 1'b0;
    end
  end

  assign oTIMEOUT = timeout;
`else
  assign wd_hit   = 1'b0;
  assign oTIMEOUT = 1'b0;
`endif

  // Outputs decode straight from state so reset drops them without a clock.
  assign oSTART     = (state == S_STREAM) || (state == S_SNAP) || (state == S_HOLD);
  assign oEND       = (state == S_HOLD);
  assign oREADY     = (state == S_IDLE) || (state == S_HOLD);
  assign oFRAME_CNT = frame_cnt;
  assign oSTATE     = state;

endmodule

// File: doc/capture_sequencer.md
CAPTURE_SEQUENCER -- requirements
Module: capture_sequencer

Interface
REQ-001 Parameters SHALL be: SNAP_W, default 8, width of the snapshot frame count; TIMEOUT_CYCLES, default 50_000_000, frame-edge watchdog limit in iCLK cycles.
REQ-002 iCLK  in  1  system clock (CLOCK_50 domain); all state on its rising edge.
REQ-003 iRST_N  in  1  reset, asynchronous and active-low.
REQ-004 iCMD  in  3  HPS command levels: bit0 RUN, bit1 SNAP, bit2 ABORT; synchronous to iCLK.
REQ-005 iFVAL  in  1  camera frame-valid; pixel-clock domain, treated as asynchronous.
REQ-006 iSNAP_FRAMES  in  SNAP_W  number of frames to capture after SNAP; sampled on SNAP acceptance.
REQ-007 oSTART  out  1  capture-run level to the CCD capture block.
REQ-008 oEND  out  1  capture-freeze level to the CCD capture block.
REQ-009 oREADY  out  1  high in IDLE and HOLD; this is the HPS handshake.
REQ-010 oFRAME_CNT  out  SNAP_W  count of frames completed since SNAP acceptance.
REQ-011 oSTATE  out  3  current state encoding, for debug.
REQ-012 oTIMEOUT  out  1  sticky watchdog flag.

Function
REQ-013 iFVAL SHALL pass through a 2-flop synchronizer; a frame boundary is the falling edge of the synchronized signal, detected one cycle later. oSTART therefore rises 3 iCLK cycles after iFVAL falls.
REQ-014 iCMD bits SHALL be rising-edge detected. Commands act on edges only, except ABORT and the HOLD exit (REQ-019).
REQ-015 The states SHALL be IDLE=0, ARM=1, STREAM=2, SNAP=3, HOLD=4.
REQ-016 IDLE: oSTART=0, oEND=0, oREADY=1. A RUN edge moves to ARM. A SNAP edge alone is ignored.
REQ-017 ARM: on the first frame boundary, set oSTART=1 and move to STREAM.
REQ-018 STREAM: a SNAP edge latches N=iSNAP_FRAMES (0 treated as 1), clears oFRAME_CNT and moves to SNAP. A RUN falling edge returns to IDLE with oSTART=0.
REQ-019 SNAP: each frame boundary increments oFRAME_CNT. On the boundary where the count reaches N, set oEND=1 and move to HOLD in the same cycle. HOLD: oSTART=1, oEND=1, oREADY=1, and the state is held until the RUN level is 0, then IDLE.
REQ-020 ABORT high in any state SHALL force IDLE on the next edge, with oSTART=0 and oEND=0; ABORT takes priority over every other event in that cycle.
REQ-021 RUN and SNAP rising in the same cycle in IDLE: RUN SHALL be honoured and SNAP discarded.
REQ-022 oFRAME_CNT SHALL saturate at all-ones and never wrap.
REQ-023 oFRAME_CNT SHALL hold its value through HOLD and IDLE; it clears only on SNAP acceptance.

Reset
REQ-024 Asserting iRST_N low SHALL asynchronously force IDLE and clear all of the following to 0: synchronizer flops, edge registers, oSTART, oEND, oFRAME_CNT and oTIMEOUT. oREADY=1 while in reset.
REQ-025 Reset mid-capture SHALL drop oSTART and oEND immediately, with no wait for a frame boundary.

Configuration
REQ-026 Macro CAPTURE_SEQ_WATCHDOG_EN, when defined, SHALL add a watchdog counter.
- The counter runs in ARM and SNAP and reloads on each frame boundary.
- On reaching TIMEOUT_CYCLES it sets oTIMEOUT=1 and forces IDLE.
- oTIMEOUT clears only on reset or a RUN edge.
REQ-027 When CAPTURE_SEQ_WATCHDOG_EN is undefined: no counter is built, oTIMEOUT is tied to 0, and ARM/SNAP wait indefinitely.

Structure
REQ-028 A shared package capture_pkg SHALL hold:
- the state enumeration;
- iCMD bit-index constants RUN/SNAP/ABORT;
- the default TIMEOUT_CYCLES.
REQ-029 The synchronizer plus falling-edge detector SHALL be a sub-module, fval_edge_sync. Everything else stays in capture_sequencer.

Verification
REQ-030 Reset, RUN edge, iFVAL falls at t -> oSTATE goes 0->1; oSTART=1 at t+3 cycles; oSTATE=2.
REQ-031 STREAM, iSNAP_FRAMES=3, SNAP edge, 3 iFVAL falls -> oFRAME_CNT 1,2,3; oEND=1 on the third; oSTATE=4; oREADY=1. Then RUN=0 -> IDLE, oSTART=0, oEND=0.
REQ-032 iSNAP_FRAMES=0 -> oEND after exactly 1 frame boundary.
REQ-033 ABORT pulsed mid-SNAP while a frame boundary is arriving in the same cycle -> IDLE next cycle; oSTART=0; oEND=0; oFRAME_CNT not incremented.
REQ-034 Macro defined, TIMEOUT_CYCLES=100, iFVAL held high in ARM -> oTIMEOUT=1 at cycle 100; IDLE. A RUN edge then clears oTIMEOUT.
REQ-035 iRST_N asserted low in HOLD -> oSTART=0, oEND=0 and oFRAME_CNT=0 without waiting for an iCLK edge.
